// File: rtl/moka_rv32i_dmem_ctrl.sv
// RV32I data-memory controller: single-outstanding load/store to an internal word array,
// with configurable wait states, byte/half/word lanes, fault detection and a fault counter.
module moka_rv32i_dmem_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  localparam int unsigned IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CntInit = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzWord = 2'b10;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [7:0]        err_cnt_q;

  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              enter_resp;

  assign req_ready = rstn & en & (state_q == StIdle);
  assign accept    = req_valid & req_ready;

  // With zero wait states the access completes on the acceptance edge, so the
  // datapath must see the live request rather than the latched copy.
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_we;
  logic [1:0]        acc_size;
  logic              acc_uns;
  logic [31:0]       acc_wdata;

  assign acc_addr  = (state_q == StIdle) ? req_addr     : addr_q;
  assign acc_we    = (state_q == StIdle) ? req_we       : we_q;
  assign acc_size  = (state_q == StIdle) ? req_size     : size_q;
  assign acc_uns   = (state_q == StIdle) ? req_unsigned : uns_q;
  assign acc_wdata = (state_q == StIdle) ? req_wdata    : wdata_q;

  logic [ADDR_W-1:0] word_idx;
  logic [IdxW-1:0]   mem_idx;
  logic              out_of_range;
  logic              misaligned;
  logic              fault;

  assign word_idx     = acc_addr >> 2;
  assign mem_idx      = word_idx[IdxW-1:0];
  assign out_of_range = (word_idx >= ADDR_W'(DEPTH));

  always_comb begin
    misaligned = 1'b0;
    case (acc_size)
      SzByte:  misaligned = 1'b0;
      SzHalf:  misaligned = acc_addr[0];
      SzWord:  misaligned = (acc_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  assign fault = misaligned | out_of_range;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Load path: pick the addressed lane(s) out of the stored word and extend.
  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [15:0] rd_half;
  logic [31:0] load_data;
  logic [31:0] rdata_d;

  assign rd_word  = out_of_range ? 32'd0 : mem[mem_idx];
  assign rd_shift = rd_word >> {acc_addr[1:0], 3'b000};
  assign rd_half  = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = 32'd0;
    case (acc_size)
      SzByte:  load_data = acc_uns ? {24'd0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
      SzHalf:  load_data = acc_uns ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
      SzWord:  load_data = rd_word;
      default: load_data = 32'd0;
    endcase
  end

  assign rdata_d = (fault | acc_we) ? 32'd0 : load_data;

  // Store path: replicate right-aligned data across lanes, then mask with byte enables.
  logic [3:0]  byte_en;
  logic [31:0] wr_data;
  logic        mem_we;

  always_comb begin
    byte_en = 4'b0000;
    wr_data = acc_wdata;
    case (acc_size)
      SzByte: begin
        byte_en = 4'b0001 << acc_addr[1:0];
        wr_data = {4{acc_wdata[7:0]}};
      end
      SzHalf: begin
        byte_en = acc_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{acc_wdata[15:0]}};
      end
      SzWord: begin
        byte_en = 4'b1111;
        wr_data = acc_wdata;
      end
      default: begin
        byte_en = 4'b0000;
        wr_data = acc_wdata;
      end
    endcase
  end

  // enter_resp is only reachable from live state, so a store aborted by reset never commits.
  assign mem_we = enter_resp & acc_we & ~fault;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[mem_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      addr_q  <= req_addr;
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else if (enter_resp) begin
      rdata_q <= rdata_d;
      err_q   <= fault;
      if (fault && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != StIdle);
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_moka_rv32i_dmem_ctrl.sv
// Bench for moka_rv32i_dmem_ctrl: two instances (0 and 3 wait states) checked against a
// byte-addressed reference memory model with randomized and directed accesses.
module tb_moka_rv32i_dmem_ctrl;

  localparam int unsigned Depth = 64;

  typedef struct {
    logic        tmo;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic        proto_ok;
    logic        rdy_leak;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } obs_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        en [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr [2];
  logic        req_we [2];
  logic [1:0]  req_size [2];
  logic        req_unsigned [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err [2];
  logic        busy [2];
  logic [7:0]  err_cnt [2];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] ref_mem [2][Depth*4];
  int         ref_errs [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    moka_rv32i_dmem_ctrl #(
      .ADDR_W(32),
      .DEPTH(Depth),
      .WAIT_STATES((g == 0) ? 0 : 3)
    ) u_dut (
      .clk(clk),
      .rstn(rstn),
      .en(en[g]),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_addr(req_addr[g]),
      .req_we(req_we[g]),
      .req_size(req_size[g]),
      .req_unsigned(req_unsigned[g]),
      .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err(rsp_err[g]),
      .busy(busy[g]),
      .err_cnt(err_cnt[g])
    );
  end

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Reference: byte-addressed little-endian memory, faults decided from address/size rules.
  task automatic model(input int d, input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata,
                       output logic [31:0] er, output logic ee);
    int nb;
    logic [31:0] v;
    er = 32'd0;
    v  = 32'd0;
    ee = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0) ||
         ((addr >> 2) >= Depth);
    if (ee) begin
      if (ref_errs[d] < 255) ref_errs[d]++;
      return;
    end
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    for (int i = 0; i < nb; i++) begin
      if (we) ref_mem[d][int'(addr) + i] = wdata[8*i +: 8];
      else v[8*i +: 8] = ref_mem[d][int'(addr) + i];
    end
    if (!we) begin
      case (size)
        2'd0:    er = uns ? {24'd0, v[7:0]} : {{24{v[7]}}, v[7:0]};
        2'd1:    er = uns ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        default: er = v;
      endcase
    end
  endtask

  task automatic txn(input int d, input logic we, input logic [31:0] addr, input logic [1:0] size,
                     input logic uns, input logic [31:0] wdata, input int hold, output obs_t o);
    logic [31:0] er;
    logic ee;
    int n;
    model(d, we, addr, size, uns, wdata, er, ee);
    o.exp_rdata = er;
    o.exp_err   = ee;
    o.tmo = 1'b0; o.lat = 0; o.rdata = 32'd0; o.err = 1'b0; o.proto_ok = 1'b1; o.rdy_leak = 1'b0;
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_size[d] = size;
    req_unsigned[d] = uns; req_wdata[d] = wdata; rsp_ready[d] = 1'b0;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) begin
      o.tmo = 1'b1;
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    do begin
      @(negedge clk);
      o.lat++;
    end while (!rsp_valid[d] && o.lat < 40);
    if (!rsp_valid[d]) begin
      o.tmo = 1'b1;
      return;
    end
    o.rdata = rsp_rdata[d];
    o.err   = rsp_err[d];
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (!rsp_valid[d] || rsp_rdata[d] !== o.rdata || rsp_err[d] !== o.err) o.proto_ok = 1'b0;
      if (req_ready[d]) o.rdy_leak = 1'b1;
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[d] = 1'b0;
    if (rsp_valid[d] || busy[d]) o.proto_ok = 1'b0;
  endtask

  task automatic test_reset();
    #3 rstn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({rsp_valid[d], rsp_err[d], busy[d], req_ready[d], err_cnt[d], rsp_rdata[d]} !== 44'd0) begin
        n_errors++;
        $display("FAIL reset_outputs[%0d]: got v=%b e=%b busy=%b rdy=%b cnt=%0d rd=%h want all 0", d,
                 rsp_valid[d], rsp_err[d], busy[d], req_ready[d], err_cnt[d], rsp_rdata[d]);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (req_ready[d] !== 1'b1) begin
        n_errors++;
        $display("FAIL reset_release_ready[%0d]: got %b want 1", d, req_ready[d]);
      end
    end
  endtask

  task automatic test_fill();
    obs_t o;
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < Depth; w++) begin
        txn(d, 1'b1, 32'(w * 4), 2'd2, 1'b0, $urandom, 0, o);
        n_checks++;
        if ({o.tmo, o.err, o.rdata} !== 34'd0 || o.lat != ws(d) + 1) begin
          n_errors++;
          $display("FAIL fill[%0d][%0d]: got tmo=%b err=%b rd=%h lat=%0d want 0/0/0/%0d", d, w,
                   o.tmo, o.err, o.rdata, o.lat, ws(d) + 1);
        end
      end
    end
  endtask

  task automatic test_directed();
    obs_t o;
    logic [31:0] want [6];
    logic [31:0] got [6];
    txn(0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 0, o);
    n_checks++;
    if (o.tmo || o.lat != 1 || o.err !== 1'b0 || o.rdata !== 32'd0) begin
      n_errors++;
      $display("FAIL dir_store_word: got lat=%0d err=%b rd=%h want lat=1 err=0 rd=0", o.lat, o.err,
               o.rdata);
    end
    txn(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'd0, 0, o);
    n_checks++;
    if (o.tmo || o.lat != 1 || o.err !== 1'b0 || o.rdata !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL dir_load_word: got lat=%0d err=%b rd=%h want lat=1 err=0 rd=deadbeef", o.lat,
               o.err, o.rdata);
    end
    txn(0, 1'b1, 32'h13, 2'd0, 1'b0, 32'h00000080, 0, o);
    txn(0, 1'b0, 32'h13, 2'd0, 1'b0, 32'd0, 0, o);
    got[0] = o.rdata; want[0] = 32'hFFFFFF80;
    txn(0, 1'b0, 32'h13, 2'd0, 1'b1, 32'd0, 0, o);
    got[1] = o.rdata; want[1] = 32'h00000080;
    txn(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'd0, 0, o);
    got[2] = o.rdata; want[2] = 32'h80ADBEEF;
    txn(0, 1'b0, 32'h11, 2'd1, 1'b0, 32'd0, 0, o);
    got[3] = {o.err, o.rdata[30:0] | {30'd0, o.rdata[31]}}; want[3] = 32'h80000000;
    txn(0, 1'b1, 32'h12, 2'd2, 1'b0, 32'h12345678, 0, o);
    got[4] = {o.err, o.rdata[30:0] | {30'd0, o.rdata[31]}}; want[4] = 32'h80000000;
    txn(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'd0, 0, o);
    got[5] = o.rdata; want[5] = 32'h80ADBEEF;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (got[i] !== want[i]) begin
        n_errors++;
        $display("FAIL dir_step%0d: got %h want %h", i, got[i], want[i]);
      end
    end
    n_checks++;
    if (err_cnt[0] !== 8'd2) begin
      n_errors++;
      $display("FAIL dir_err_cnt: got %0d want 2", err_cnt[0]);
    end
  endtask

  task automatic test_wait_hold();
    obs_t o;
    txn(1, 1'b0, 32'h20, 2'd2, 1'b0, 32'd0, 5, o);
    n_checks++;
    if (o.tmo || o.lat != 4) begin
      n_errors++;
      $display("FAIL hold_latency: got lat=%0d tmo=%b want lat=4", o.lat, o.tmo);
    end
    n_checks++;
    if (!o.proto_ok || o.rdy_leak || o.rdata !== o.exp_rdata || o.err !== 1'b0) begin
      n_errors++;
      $display("FAIL hold_stable: got ok=%b leak=%b rd=%h want ok=1 leak=0 rd=%h", o.proto_ok,
               o.rdy_leak, o.rdata, o.exp_rdata);
    end
    n_checks++;
    if (req_ready[1] !== 1'b1) begin
      n_errors++;
      $display("FAIL hold_ready_after: got %b want 1", req_ready[1]);
    end
  endtask

  task automatic test_enable();
    logic seen;
    logic [31:0] er;
    logic ee;
    int n;
    en[1] = 1'b0;
    seen = 1'b0;
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h24; req_size[1] = 2'd2;
    repeat (4) begin
      @(negedge clk);
      if (busy[1] || req_ready[1]) seen = 1'b1;
    end
    req_valid[1] = 1'b0;
    n_checks++;
    if (seen !== 1'b0) begin
      n_errors++;
      $display("FAIL en_gate: got accepted=%b want 0", seen);
    end
    en[1] = 1'b1;
    model(1, 1'b0, 32'h24, 2'd2, 1'b0, 32'd0, er, ee);
    @(negedge clk);
    req_valid[1] = 1'b1;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    en[1] = 1'b0;
    n = 0;
    while (!rsp_valid[1] && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== er || rsp_err[1] !== ee) begin
      n_errors++;
      $display("FAIL en_midflight: got v=%b rd=%h err=%b want v=1 rd=%h err=%b", rsp_valid[1],
               rsp_rdata[1], rsp_err[1], er, ee);
    end
    rsp_ready[1] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[1] = 1'b0;
    n_checks++;
    if ({busy[1], req_ready[1]} !== 2'b00) begin
      n_errors++;
      $display("FAIL en_exit: got busy=%b rdy=%b want 0 0", busy[1], req_ready[1]);
    end
    en[1] = 1'b1;
    #1;
    n_checks++;
    if (req_ready[1] !== 1'b1) begin
      n_errors++;
      $display("FAIL en_restore: got %b want 1", req_ready[1]);
    end
  endtask

  task automatic test_random();
    obs_t o;
    int d;
    logic [1:0] sz;
    for (int i = 0; i < 300; i++) begin
      d  = int'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      txn(d, 1'($urandom), 32'($urandom_range(0, Depth * 4 + 7)), sz, 1'($urandom), $urandom,
          int'($urandom_range(0, 2)), o);
      n_checks++;
      if ({o.tmo, o.err, o.rdata} !== {1'b0, o.exp_err, o.exp_rdata}) begin
        n_errors++;
        $display("FAIL rnd_rsp[%0d]: got tmo=%b err=%b rd=%h want err=%b rd=%h", i, o.tmo, o.err,
                 o.rdata, o.exp_err, o.exp_rdata);
      end
      n_checks++;
      if (o.lat != ws(d) + 1 || !o.proto_ok || o.rdy_leak) begin
        n_errors++;
        $display("FAIL rnd_timing[%0d]: got lat=%0d ok=%b leak=%b want lat=%0d ok=1 leak=0", i,
                 o.lat, o.proto_ok, o.rdy_leak, ws(d) + 1);
      end
      n_checks++;
      if (err_cnt[d] !== 8'(ref_errs[d])) begin
        n_errors++;
        $display("FAIL rnd_err_cnt[%0d]: got %0d want %0d", i, err_cnt[d], ref_errs[d]);
      end
    end
  endtask

  task automatic test_reset_abort();
    obs_t o;
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h40; req_size[1] = 2'd2;
    req_wdata[1] = {ref_mem[1][67], ref_mem[1][66], ref_mem[1][65], ref_mem[1][64]} ^ 32'hFFFF_FFFF;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({rsp_valid[1], rsp_err[1], busy[1], req_ready[1], err_cnt[1], rsp_rdata[1]} !== 44'd0) begin
      n_errors++;
      $display("FAIL abort_reset: got v=%b e=%b busy=%b rdy=%b cnt=%0d rd=%h want all 0",
               rsp_valid[1], rsp_err[1], busy[1], req_ready[1], err_cnt[1], rsp_rdata[1]);
    end
    ref_errs[0] = 0;
    ref_errs[1] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    txn(1, 1'b0, 32'h40, 2'd2, 1'b0, 32'd0, 0, o);
    n_checks++;
    if (o.tmo || o.err !== 1'b0 || o.rdata !== o.exp_rdata) begin
      n_errors++;
      $display("FAIL abort_old_data: got err=%b rd=%h want err=0 rd=%h", o.err, o.rdata,
               o.exp_rdata);
    end
  endtask

  task automatic test_saturate();
    obs_t o;
    logic bad;
    txn(0, 1'b0, 32'(Depth * 4), 2'd2, 1'b0, 32'd0, 0, o);
    n_checks++;
    if (o.tmo || o.err !== 1'b1 || o.rdata !== 32'd0) begin
      n_errors++;
      $display("FAIL sat_oob: got err=%b rd=%h want err=1 rd=0", o.err, o.rdata);
    end
    bad = 1'b0;
    for (int i = 0; i < 256; i++) begin
      txn(0, 1'($urandom), $urandom_range(0, 255), 2'd3, 1'b0, $urandom, 0, o);
      if (o.tmo || o.err !== 1'b1) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_errors++;
      $display("FAIL sat_faults: got some non-faulting illegal-size response, want all rsp_err=1");
    end
    n_checks++;
    if (err_cnt[0] !== 8'd255) begin
      n_errors++;
      $display("FAIL sat_err_cnt: got %0d want 255", err_cnt[0]);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b1; req_valid[d] = 1'b0; req_addr[d] = 32'd0; req_we[d] = 1'b0;
      req_size[d] = 2'd0; req_unsigned[d] = 1'b0; req_wdata[d] = 32'd0; rsp_ready[d] = 1'b0;
      ref_errs[d] = 0;
    end
    test_reset();
    test_fill();
    test_directed();
    test_wait_hold();
    test_enable();
    test_random();
    test_reset_abort();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/moka_rv32i_dmem_ctrl.md
MOKA_RV32I_DMEM_CTRL -- requirements
Module: moka_rv32i_dmem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-002 SHALL have parameter DEPTH, default 1024: number of 32-bit words in the internal data array.
REQ-003 SHALL have parameter WAIT_STATES, default 0: extra cycles per access, legal range 0..15.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port en, input, 1 bit: block enable; gates acceptance of new requests.
REQ-007 SHALL have port req_valid, input, 1 bit: request present.
REQ-008 SHALL have port req_ready, output, 1 bit: request can be accepted.
REQ-009 SHALL have port req_addr, input, ADDR_W bits: byte address.
REQ-010 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-011 SHALL have port req_size, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-012 SHALL have port req_unsigned, input, 1 bit: 1 = zero-extend loads, 0 = sign-extend loads.
REQ-013 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-014 SHALL have port rsp_valid, output, 1 bit: response present.
REQ-015 SHALL have port rsp_ready, input, 1 bit: response consumed.
REQ-016 SHALL have port rsp_rdata, output, 32 bits: load result, right-aligned and extended.
REQ-017 SHALL have port rsp_err, output, 1 bit: access faulted.
REQ-018 SHALL have port busy, output, 1 bit: FSM is not IDLE.
REQ-019 SHALL have port err_cnt, output, 8 bits: saturating count of faulted accesses.

Function
REQ-020 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-021 SHALL drive req_ready = rstn & en & (state==IDLE).
- Acceptance occurs on a rising edge where req_valid & req_ready; all req_* fields are latched at that edge.
REQ-022 SHALL, on acceptance, go to WAIT with a 4-bit counter loaded with WAIT_STATES-1 when WAIT_STATES>0, otherwise go directly to RESP.
REQ-023 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the edge where the counter equals 0.
- Result: rsp_valid first asserts exactly WAIT_STATES+1 cycles after the acceptance edge.
REQ-024 SHALL commit a store and capture load data on the edge entering RESP, never earlier.
REQ-025 SHALL flag a fault, with no write and rsp_rdata=0, when any of the following holds:
- req_size==11;
- half access with addr[0]=1;
- word access with addr[1:0]!=0;
- word index addr[ADDR_W-1:2] >= DEPTH.
REQ-026 SHALL, for a byte store, write only lane addr[1:0] with wdata[7:0]; for a half store, write lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; for a word store, write all four lanes.
REQ-027 SHALL, for a byte or half load, select the addressed lane(s) and extend to 32 bits per req_unsigned.
REQ-028 SHALL return rsp_rdata=0 for every store response.
REQ-029 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then go to IDLE on that edge.
- No request is accepted in the RESP-exit cycle; the minimum spacing between acceptances is WAIT_STATES+2 cycles.
REQ-030 SHALL let an in-flight access complete normally when en deasserts mid-access; en affects acceptance only.
REQ-031 SHALL increment err_cnt on each faulted access as it enters RESP, saturating at 255.
REQ-032 SHALL drive busy = (state != IDLE).

Reset
REQ-033 SHALL, while rstn=0, force the following immediately:
- state = IDLE, counter = 0;
- rsp_valid = 0, rsp_rdata = 0, rsp_err = 0;
- err_cnt = 0, busy = 0, req_ready = 0.
REQ-034 SHALL abort any access in flight when reset asserts; an uncommitted store SHALL NOT modify the array.
REQ-035 SHALL NOT reset the data array contents.

Verification
REQ-036 WAIT_STATES=0, word store 0xDEADBEEF to 0x10, then word load 0x10 -> rsp_valid one cycle after each acceptance; load returns 0xDEADBEEF, rsp_err=0.
REQ-037 Byte store 0x80 to 0x13, then byte load 0x13 with req_unsigned=0 -> 0xFFFFFF80; same load with req_unsigned=1 -> 0x00000080; word load 0x10 -> 0x80ADBEEF.
REQ-038 Half load at 0x11 and word store at 0x12 -> rsp_err=1 for both, array unchanged, err_cnt increments by 2.
REQ-039 WAIT_STATES=3, load accepted at cycle 0 with rsp_ready held 0 for 5 cycles -> rsp_valid rises at cycle 4 and holds stable; req_ready=0 until the cycle after rsp_ready=1.
REQ-040 WAIT_STATES=3, store accepted, rstn pulsed low 1 cycle later -> all outputs go to reset values asynchronously; a subsequent load of that address returns the old data.
REQ-041 Word load at word index DEPTH -> rsp_err=1, rsp_rdata=0; 256 further faults -> err_cnt holds at 255.
